multicycle_control_fsm: RTL

Multi-cycle control unit that sits directly upstream of the 16-bit CPU datapath. It consumes the 3-bit opcode (instruction[15:13]) and the ALU zero flag from the datapath. It sequences the datapath control lines (RegDst, Branch, MemRead, MemWrite, RegWrite, MemToReg, ALUSrc, ALUOp) over several cycles per instruction. It also handshakes with instruction and data memories that may insert wait states.

---
 rtl/multicycle_control_fsm.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle control unit for the 16-bit CPU datapath. It sequences the datapath control lines and waits on instruction/data memory handshakes.
// Optional retired-instruction counter enabled by defining CTRL_PERF_CNT_EN.
module multicycle_control_fsm #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 4
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [2:0]  Opcode,
  input  logic        Zero,
  input  logic        InstrReady,
  input  logic        MemReady,
  output logic        RegDst,
  output logic        Branch,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        RegWrite,
  output logic        MemToReg,
  output logic        ALUSrc,
  output logic [1:0]  ALUOp,
  output logic        PCWrite,
  output logic        IRWrite,
  output logic [1:0]  PCSrc,
  output logic [2:0]  State,
  output logic        Timeout,
  output logic [15:0] InstrCount
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    BRANCH = 3'd5,
    JUMP   = 3'd6,
    TRAP   = 3'd7
  } state_t;

  localparam logic [2:0] OP_R      = 3'b000;
  localparam logic [2:0] OP_ADDI   = 3'b001;
  localparam logic [2:0] OP_UNUSED = 3'b010;
  localparam logic [2:0] OP_LW     = 3'b011;
  localparam logic [2:0] OP_SW     = 3'b100;
  localparam logic [2:0] OP_BEQ    = 3'b101;
  localparam logic [2:0] OP_BNE    = 3'b110;
  localparam logic [2:0] OP_JUMP   = 3'b111;

  state_t           state, state_next;
  logic [2:0]       opcode_q;
  logic [CNT_W-1:0] wait_cnt;
  logic             waiting;
  logic             limit_hit;

  always_comb begin
    waiting    = ((state == FETCH) && !InstrReady) || ((state == MEM) && !MemReady);
    limit_hit  = (MEM_TIMEOUT != 0) && (wait_cnt == CNT_W'(MEM_TIMEOUT));
    state_next = state;
    case (state)
      FETCH: begin
        if (InstrReady)     state_next = DECODE;
        else if (limit_hit) state_next = TRAP;
      end
      DECODE: begin
        case (Opcode)
          OP_BEQ, OP_BNE: state_next = BRANCH;
          OP_JUMP:        state_next = JUMP;
          default:        state_next = EXEC;
        endcase
      end
      EXEC:   state_next = ((opcode_q == OP_LW) || (opcode_q == OP_SW)) ? MEM : WB;
      MEM: begin
        if (MemReady)       state_next = (opcode_q == OP_LW) ? WB : FETCH;
        else if (limit_hit) state_next = TRAP;
      end
      WB, BRANCH, JUMP: state_next = FETCH;
      default:          state_next = TRAP;
    endcase
  end

  // The wait counter restarts on every state change so each wait phase gets the full budget.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state    <= FETCH;
      opcode_q <= '0;
      wait_cnt <= '0;
    end else begin
      state <= state_next;
      if (state == DECODE) opcode_q <= Opcode;
      if (state_next != state) wait_cnt <= '0;
      else if (waiting)        wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Everything is forced low while Reset is high, even the input-qualified FETCH strobes.
  always_comb begin
    RegDst   = 1'b0;
    Branch   = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    RegWrite = 1'b0;
    MemToReg = 1'b0;
    ALUSrc   = 1'b0;
    ALUOp    = 2'b00;
    PCWrite  = 1'b0;
    IRWrite  = 1'b0;
    PCSrc    = 2'b00;
    Timeout  = 1'b0;
    if (!Reset) begin
      case (state)
        FETCH: begin
          IRWrite = InstrReady;
          PCWrite = InstrReady;
        end
        EXEC, MEM, WB: begin
          case (opcode_q)
            OP_R: begin
              RegDst = 1'b1;
              ALUOp  = 2'b10;
            end
            OP_ADDI, OP_UNUSED: begin
              ALUSrc = 1'b1;
              ALUOp  = 2'b11;
            end
            default: begin
              ALUSrc = 1'b1;
              ALUOp  = 2'b00;
            end
          endcase
          if (state == MEM) begin
            MemRead  = (opcode_q == OP_LW);
            MemWrite = (opcode_q == OP_SW);
          end
          if (state == WB) begin
            RegWrite = 1'b1;
            if (opcode_q == OP_LW) begin
              MemToReg = 1'b1;
              RegDst   = 1'b0;
            end
          end
        end
        BRANCH: begin
          Branch  = 1'b1;
          ALUOp   = 2'b01;
          PCSrc   = 2'b01;
          PCWrite = (opcode_q == OP_BEQ) ? Zero : ~Zero;
        end
        JUMP: begin
          PCWrite = 1'b1;
          PCSrc   = 2'b10;
        end
        TRAP:    Timeout = 1'b1;
        default: ;
      endcase
    end
  end

  assign State = state;

`ifdef CTRL_PERF_CNT_EN
  logic        retire;
  logic [15:0] instr_count_q;

  assign retire = (state_next == FETCH) && (state != FETCH);

  // Wraps naturally from 16'hFFFF back to 0.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset)       instr_count_q <= '0;
    else if (retire) instr_count_q <= instr_count_q + 16'd1;
  end

  assign InstrCount = instr_count_q;
`else
  assign InstrCount = '0;
`endif

endmodule
